// File: rtl/smith_waterman_pe_cfg_if.sv
// Chain-side bus of the configurable affine-gap Smith-Waterman PE.
// dir_out is present only when SW_PE_TRACEBACK_EN is defined.
interface smith_waterman_pe_cfg_if #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned SYM_W = 2,
    parameter int unsigned PEN_W = 6,
    parameter int unsigned COL_W = 16
);
    logic [WIDTH-1:0]   V_in;
    logic [WIDTH-1:0]   F_in;
    logic [SYM_W-1:0]   T_in;
    logic [SYM_W-1:0]   S_in;
    logic               store_S_in;
    logic               init_in;
    logic [WIDTH-1:0]   init_V;
    logic [WIDTH-1:0]   init_E;
    logic               cfg_we_in;
    logic [4*PEN_W-1:0] cfg_in;

    logic [WIDTH-1:0]   V_out;
    logic [WIDTH-1:0]   E_out;
    logic [WIDTH-1:0]   F_out;
    logic [SYM_W-1:0]   T_out;
    logic [SYM_W-1:0]   S_out;
    logic               store_S_out;
    logic               init_out;
    logic               cfg_we_out;
    logic [4*PEN_W-1:0] cfg_out;
    logic [WIDTH-1:0]   max_score_out;
    logic [COL_W-1:0]   max_col_out;
`ifdef SW_PE_TRACEBACK_EN
    logic [1:0]         dir_out;
`endif

    modport slave (
`ifdef SW_PE_TRACEBACK_EN
        output dir_out,
`endif
        input  V_in, F_in, T_in, S_in, store_S_in, init_in, init_V, init_E,
               cfg_we_in, cfg_in,
        output V_out, E_out, F_out, T_out, S_out, store_S_out, init_out,
               cfg_we_out, cfg_out, max_score_out, max_col_out
    );

    modport master (
`ifdef SW_PE_TRACEBACK_EN
        input  dir_out,
`endif
        output V_in, F_in, T_in, S_in, store_S_in, init_in, init_V, init_E,
               cfg_we_in, cfg_in,
        input  V_out, E_out, F_out, T_out, S_out, store_S_out, init_out,
               cfg_we_out, cfg_out, max_score_out, max_col_out
    );
endinterface

// File: rtl/smith_waterman_pe_cfg.sv
// Affine-gap Smith-Waterman systolic PE with chained runtime scoring config,
// saturating scores and a running max tracker. SW_PE_TRACEBACK_EN adds dir_out.
module smith_waterman_pe_cfg #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned SYM_W = 2,
    parameter int unsigned PEN_W = 6,
    parameter int unsigned COL_W = 16
) (
    input logic                    clk,
    input logic                    rst,
    input logic                    stall,
    smith_waterman_pe_cfg_if.slave bus
);
    localparam int unsigned CFG_W = 4 * PEN_W;
    localparam int unsigned EXT_W = WIDTH - PEN_W;

    typedef logic signed [WIDTH-1:0] score_t;

    localparam score_t ZERO = '0;
    localparam score_t SMAX = score_t'({1'b0, {(WIDTH-1){1'b1}}});
    localparam score_t SMIN = score_t'({1'b1, {(WIDTH-1){1'b0}}});

    function automatic score_t sext(input logic [PEN_W-1:0] p);
        return score_t'({{EXT_W{p[PEN_W-1]}}, p});
    endfunction

    // One guard bit detects overflow; clamp toward the sign of the true sum.
    function automatic score_t sat_add(input score_t a, input score_t b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SMIN : SMAX;
        return score_t'(s[WIDTH-1:0]);
    endfunction

    function automatic score_t smax(input score_t a, input score_t b);
        return (a > b) ? a : b;
    endfunction

    score_t             v_q, v_d, e_q, e_d, f_q, f_d, vdiag_q, vdiag_d;
    score_t             max_score_q, max_score_d;
    logic [SYM_W-1:0]   t_q, t_d, s_q, s_d;
    logic               store_s_q, store_s_d, init_q, init_d, cfg_we_q, cfg_we_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic [PEN_W-1:0]   match_q, match_d, mismatch_q, mismatch_d;
    logic [PEN_W-1:0]   open_q, open_d, extend_q, extend_d;
    logic [COL_W-1:0]   col_q, col_d, max_col_q, max_col_d;

    score_t             pen_diag, new_e, new_f, new_v, diag;

    // Cell recurrence for the current column.
    always_comb begin
        pen_diag = (s_q == bus.T_in) ? sext(match_q) : sext(mismatch_q);
        new_e    = smax(sat_add(v_q, sext(open_q)), sat_add(e_q, sext(extend_q)));
        new_f    = smax(sat_add($signed(bus.V_in), sext(open_q)),
                        sat_add($signed(bus.F_in), sext(extend_q)));
        diag     = sat_add(vdiag_q, pen_diag);
        new_v    = smax(smax(ZERO, new_e), smax(new_f, diag));
    end

`ifdef SW_PE_TRACEBACK_EN
    logic [1:0] dir_q, dir_d, new_dir;

    always_comb begin
        if (new_v == ZERO)      new_dir = 2'd0;
        else if (new_v == diag) new_dir = 2'd1;
        else if (new_v == new_f) new_dir = 2'd2;
        else                    new_dir = 2'd3;
    end
`endif

    always_comb begin
        v_d         = v_q;
        e_d         = e_q;
        f_d         = f_q;
        vdiag_d     = vdiag_q;
        max_score_d = max_score_q;
        t_d         = t_q;
        s_d         = s_q;
        store_s_d   = store_s_q;
        init_d      = init_q;
        cfg_we_d    = cfg_we_q;
        cfg_d       = cfg_q;
        match_d     = match_q;
        mismatch_d  = mismatch_q;
        open_d      = open_q;
        extend_d    = extend_q;
        col_d       = col_q;
        max_col_d   = max_col_q;
`ifdef SW_PE_TRACEBACK_EN
        dir_d       = dir_q;
`endif
        if (!stall) begin
            t_d       = bus.T_in;
            store_s_d = bus.store_S_in;
            init_d    = bus.init_in;
            cfg_we_d  = bus.cfg_we_in;
            cfg_d     = bus.cfg_in;
            vdiag_d   = $signed(bus.V_in);
            if (bus.store_S_in) s_d = bus.S_in;
            if (bus.cfg_we_in) begin
                match_d    = bus.cfg_in[4*PEN_W-1 -: PEN_W];
                mismatch_d = bus.cfg_in[3*PEN_W-1 -: PEN_W];
                open_d     = bus.cfg_in[2*PEN_W-1 -: PEN_W];
                extend_d   = bus.cfg_in[PEN_W-1:0];
            end
            if (bus.init_in) begin
                v_d   = new_v;
                e_d   = new_e;
                f_d   = new_f;
                col_d = col_q + COL_W'(1);
`ifdef SW_PE_TRACEBACK_EN
                dir_d = new_dir;
`endif
            end else begin
                v_d   = $signed(bus.init_V);
                e_d   = $signed(bus.init_E);
                col_d = '0;
`ifdef SW_PE_TRACEBACK_EN
                dir_d = 2'd0;
`endif
            end
            // Clear beats update; strict compare keeps the earliest column on ties.
            if (bus.store_S_in) begin
                max_score_d = ZERO;
                max_col_d   = '0;
            end else if (bus.init_in && (new_v > max_score_q)) begin
                max_score_d = new_v;
                max_col_d   = col_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            e_q         <= '0;
            f_q         <= '0;
            vdiag_q     <= '0;
            max_score_q <= '0;
            t_q         <= '0;
            s_q         <= '0;
            store_s_q   <= 1'b0;
            init_q      <= 1'b0;
            cfg_we_q    <= 1'b0;
            cfg_q       <= '0;
            match_q     <= '0;
            mismatch_q  <= '0;
            open_q      <= '0;
            extend_q    <= '0;
            col_q       <= '0;
            max_col_q   <= '0;
`ifdef SW_PE_TRACEBACK_EN
            dir_q       <= 2'd0;
`endif
        end else begin
            v_q         <= v_d;
            e_q         <= e_d;
            f_q         <= f_d;
            vdiag_q     <= vdiag_d;
            max_score_q <= max_score_d;
            t_q         <= t_d;
            s_q         <= s_d;
            store_s_q   <= store_s_d;
            init_q      <= init_d;
            cfg_we_q    <= cfg_we_d;
            cfg_q       <= cfg_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            open_q      <= open_d;
            extend_q    <= extend_d;
            col_q       <= col_d;
            max_col_q   <= max_col_d;
`ifdef SW_PE_TRACEBACK_EN
            dir_q       <= dir_d;
`endif
        end
    end

    assign bus.V_out         = v_q;
    assign bus.E_out         = e_q;
    assign bus.F_out         = f_q;
    assign bus.T_out         = t_q;
    assign bus.S_out         = s_q;
    assign bus.store_S_out   = store_s_q;
    assign bus.init_out      = init_q;
    assign bus.cfg_we_out    = cfg_we_q;
    assign bus.cfg_out       = cfg_q;
    assign bus.max_score_out = max_score_q;
    assign bus.max_col_out   = max_col_q;
`ifdef SW_PE_TRACEBACK_EN
    assign bus.dir_out       = dir_q;
`endif

endmodule

// File: tb/tb_smith_waterman_pe_cfg.sv
// Scoreboard bench for smith_waterman_pe_cfg: an integer-arithmetic cell model
// predicts each cycle's outputs; a monitor compares them after every clock edge.
module tb_smith_waterman_pe_cfg;
    localparam int WIDTH = 12;
    localparam int SYM_W = 2;
    localparam int PEN_W = 6;
    localparam int COL_W = 16;
    localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
    localparam int SMIN  = -(1 << (WIDTH - 1));

    logic clk = 1'b0;
    logic rst;
    logic stall;

    smith_waterman_pe_cfg_if #(.WIDTH(WIDTH), .SYM_W(SYM_W), .PEN_W(PEN_W), .COL_W(COL_W)) bus ();

    smith_waterman_pe_cfg #(.WIDTH(WIDTH), .SYM_W(SYM_W), .PEN_W(PEN_W), .COL_W(COL_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .stall(stall),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall;
        bit          store;
        bit          init;
        bit          cfgwe;
        int          v_in, f_in, iv, ie, t, s;
        logic [23:0] cfg;
    } stim_t;

    typedef struct {
        int          v, e, f, t, s, store, init, cfgwe, mx, mc, dir;
        logic [23:0] cfg;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers).
    int m_v, m_e, m_f, m_vd, m_s, m_t, m_store, m_init, m_cfgwe;
    int m_match, m_mis, m_open, m_ext, m_col, m_max, m_maxcol, m_dir;
    logic [23:0] m_cfg;

    function automatic int sat(int a, int b);
        int r = a + b;
        if (r > SMAX) return SMAX;
        if (r < SMIN) return SMIN;
        return r;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sx(logic [PEN_W-1:0] p);
        return int'($signed(p));
    endfunction

    function automatic logic [23:0] mkcfg(int ma, int mm, int op, int ex);
        logic [23:0] c;
        c = {6'(ma), 6'(mm), 6'(op), 6'(ex)};
        return c;
    endfunction

    task automatic model_reset();
        m_v = 0; m_e = 0; m_f = 0; m_vd = 0; m_s = 0; m_t = 0; m_store = 0;
        m_init = 0; m_cfgwe = 0; m_cfg = '0; m_match = 0; m_mis = 0; m_open = 0;
        m_ext = 0; m_col = 0; m_max = 0; m_maxcol = 0; m_dir = 0;
    endtask

    task automatic model_step(input stim_t st);
        int ne, nf, dg, nv;
        if (st.stall) return;
        ne = imax(sat(m_v, m_open), sat(m_e, m_ext));
        nf = imax(sat(st.v_in, m_open), sat(st.f_in, m_ext));
        dg = sat(m_vd, (m_s == st.t) ? m_match : m_mis);
        nv = imax(imax(0, ne), imax(nf, dg));
        if (st.store) begin
            m_max = 0; m_maxcol = 0;
        end else if (st.init && nv > m_max) begin
            m_max = nv; m_maxcol = m_col;
        end
        if (st.init) begin
            m_v = nv; m_e = ne; m_f = nf;
            m_col = (m_col + 1) % (1 << COL_W);
            m_dir = (nv == 0) ? 0 : (nv == dg) ? 1 : (nv == nf) ? 2 : 3;
        end else begin
            m_v = st.iv; m_e = st.ie; m_col = 0; m_dir = 0;
        end
        m_vd = st.v_in;
        if (st.store) m_s = st.s;
        if (st.cfgwe) begin
            m_match = sx(st.cfg[23:18]); m_mis = sx(st.cfg[17:12]);
            m_open  = sx(st.cfg[11:6]);  m_ext = sx(st.cfg[5:0]);
        end
        m_t = st.t; m_store = int'(st.store); m_init = int'(st.init);
        m_cfgwe = int'(st.cfgwe); m_cfg = st.cfg;
    endtask

    function automatic exp_t snapshot();
        exp_t x;
        x.v = m_v; x.e = m_e; x.f = m_f; x.t = m_t; x.s = m_s; x.store = m_store;
        x.init = m_init; x.cfgwe = m_cfgwe; x.cfg = m_cfg; x.mx = m_max;
        x.mc = m_maxcol; x.dir = m_dir;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all(input exp_t x);
        check("V_out", int'($signed(bus.V_out)), x.v);
        check("E_out", int'($signed(bus.E_out)), x.e);
        check("F_out", int'($signed(bus.F_out)), x.f);
        check("T_out", int'(bus.T_out), x.t);
        check("S_out", int'(bus.S_out), x.s);
        check("store_S_out", int'(bus.store_S_out), x.store);
        check("init_out", int'(bus.init_out), x.init);
        check("cfg_we_out", int'(bus.cfg_we_out), x.cfgwe);
        check("cfg_out", int'(bus.cfg_out), int'(x.cfg));
        check("max_score_out", int'($signed(bus.max_score_out)), x.mx);
        check("max_col_out", int'(bus.max_col_out), x.mc);
`ifdef SW_PE_TRACEBACK_EN
        check("dir_out", int'(bus.dir_out), x.dir);
`endif
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z = '{default: 0, cfg: '0};
        check({tag, " V_out"}, int'(bus.V_out), 0);
        check({tag, " E_out"}, int'(bus.E_out), 0);
        check({tag, " F_out"}, int'(bus.F_out), 0);
        check({tag, " T_out"}, int'(bus.T_out), 0);
        check({tag, " S_out"}, int'(bus.S_out), 0);
        check({tag, " init_out"}, int'(bus.init_out), z.init);
        check({tag, " cfg_out"}, int'(bus.cfg_out), 0);
        check({tag, " max_score_out"}, int'(bus.max_score_out), 0);
        check({tag, " max_col_out"}, int'(bus.max_col_out), 0);
`ifdef SW_PE_TRACEBACK_EN
        check({tag, " dir_out"}, int'(bus.dir_out), 0);
`endif
    endtask

    task automatic do_cycle(input stim_t st);
        @(negedge clk);
        stall          = st.stall;
        bus.V_in       = WIDTH'(st.v_in);
        bus.F_in       = WIDTH'(st.f_in);
        bus.T_in       = SYM_W'(st.t);
        bus.S_in       = SYM_W'(st.s);
        bus.store_S_in = st.store;
        bus.init_in    = st.init;
        bus.init_V     = WIDTH'(st.iv);
        bus.init_E     = WIDTH'(st.ie);
        bus.cfg_we_in  = st.cfgwe;
        bus.cfg_in     = st.cfg;
        model_step(st);
        exp_q.push_back(snapshot());
    endtask

    // Reset lands between clock edges and must clear outputs without a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        stall = 1'b1;
        #2 rst = 1'b1;
        #1 check_zero(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0, cfg: '0};
        return s;
    endfunction

    function automatic int rnd_score();
        case ($urandom_range(0, 9))
            0:       return SMAX - int'($urandom_range(0, 17));
            1:       return SMIN + int'($urandom_range(0, 17));
            default: return int'($urandom_range(0, 60)) - 20;
        endcase
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.stall = ($urandom_range(0, 9) == 0);
        s.init  = ($urandom_range(0, 7) != 0);
        s.store = ($urandom_range(0, 19) == 0);
        s.cfgwe = ($urandom_range(0, 15) == 0);
        s.cfg   = mkcfg(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)) - 32,
                        int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
        s.v_in  = rnd_score();
        s.f_in  = rnd_score();
        s.iv    = rnd_score();
        s.ie    = rnd_score();
        s.t     = int'($urandom_range(0, 3));
        s.s     = int'($urandom_range(0, 3));
        return s;
    endfunction

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                compare_all(x);
            end
        end
    end

    initial begin : driver
        stim_t s;
        int seq[5] = '{3, 9, 9, 4, 0};
        rst = 1'b0;
        stall = 1'b1;
        bus.V_in = '0; bus.F_in = '0; bus.T_in = '0; bus.S_in = '0;
        bus.store_S_in = 1'b0; bus.init_in = 1'b0; bus.init_V = '0; bus.init_E = '0;
        bus.cfg_we_in = 1'b0; bus.cfg_in = '0;
        #2 rst = 1'b1;
        #1 check_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Program {+2,-3,-4,-1} and S=2, then a matching diagonal from V_diag=5.
        s = idle(); s.cfgwe = 1; s.cfg = mkcfg(2, -3, -4, -1); s.store = 1; s.s = 2;
        do_cycle(s);
        s = idle(); s.v_in = 5; do_cycle(s);
        s = idle(); s.init = 1; s.t = 2; do_cycle(s);

        // Saturation at the positive rail, then a mismatch.
        s = idle(); s.cfgwe = 1; s.cfg = mkcfg(5, -3, -4, -1); s.v_in = 2046; do_cycle(s);
        s = idle(); s.init = 1; s.t = 2; do_cycle(s);
        s = idle(); s.init = 1; s.t = 1; s.f_in = SMIN; do_cycle(s);

        // Gap extension from V=10, E=8 with a mismatching diagonal.
        s = idle(); s.cfgwe = 1; s.cfg = mkcfg(2, -3, -4, -1); s.iv = 10; s.ie = 8; do_cycle(s);
        s = idle(); s.init = 1; s.t = 0; do_cycle(s);

        // Max tracker: diag-only V sequence 3,9,9,4 after a clear, then a clear pulse.
        s = idle(); s.cfgwe = 1; s.cfg = mkcfg(0, -3, -31, -1); s.store = 1; s.s = 2;
        s.v_in = seq[0]; s.f_in = SMIN; do_cycle(s);
        for (int i = 1; i < 5; i++) begin
            s = idle(); s.init = 1; s.t = 2; s.v_in = seq[i]; s.f_in = SMIN; do_cycle(s);
        end
        s = idle(); s.init = 1; s.store = 1; s.s = 2; s.t = 2; s.f_in = SMIN; do_cycle(s);

        // Three-cycle stall in the middle of an active run.
        for (int i = 0; i < 6; i++) begin
            s = rnd_stim(); s.init = 1; s.stall = (i >= 1 && i <= 3); do_cycle(s);
        end

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) async_reset("midrun reset");
            do_cycle(rnd_stim());
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/smith_waterman_pe_cfg.md
Name: smith_waterman_pe_cfg

Overview:
- Next-generation affine-gap Smith-Waterman systolic PE; one instance per query symbol, chained in the array.
- Differences from the fixed-scoring PE:
  - parametrised score and symbol widths;
  - runtime-programmable scoring, loaded through a systolic config chain;
  - saturating arithmetic;
  - per-PE running maximum score with its reference column index.
- Computes one DP cell per non-stalled cycle and forwards V/F/T/init/config to the next PE.

Parameters:
- WIDTH, 12, score width (signed two's complement)
- SYM_W, 2, symbol width (2 = DNA, 5 = protein)
- PEN_W, 6, width of each signed scoring field
- COL_W, 16, width of column counter / max position

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  pipeline stall; freezes all state
- V_in  in  WIDTH  score from previous PE
- F_in  in  WIDTH  up-gap score from previous PE
- T_in  in  SYM_W  reference symbol shift in
- S_in  in  SYM_W  query symbol
- store_S_in  in  1  capture S_in; also clears max tracker
- init_in  in  1  computation-active shift in
- init_V  in  WIDTH  V value loaded while inactive
- init_E  in  WIDTH  E value loaded while inactive
- cfg_we_in  in  1  config write shift in
- cfg_in  in  4*PEN_W  {match, mismatch, gap_open, gap_extend}, MSB first, signed
- V_out  out  WIDTH  registered V
- E_out  out  WIDTH  registered E
- F_out  out  WIDTH  registered F
- T_out  out  SYM_W  registered T
- S_out  out  SYM_W  registered S
- store_S_out  out  1  registered store_S_in
- init_out  out  1  registered init_in
- cfg_we_out  out  1  registered cfg_we_in
- cfg_out  out  4*PEN_W  registered cfg_in
- max_score_out  out  WIDTH  running max V since last clear
- max_col_out  out  COL_W  column index of max_score_out

Behaviour:
- Reset (async, rst=1): all registers 0.
  - Includes all outputs, scoring fields (match=mismatch=open=extend=0), column counter, max_score, max_col.
  - Recovery is synchronous to clk.
- stall=1: no register changes, including config and counters.
- Each non-stalled cycle:
  - T, init, store_S, cfg_we, cfg_in shift to outputs.
  - V_diag <= V_in.
  - If store_S_in: S <= S_in.
  - If cfg_we_in: scoring registers <= cfg_in fields, effective from the next cycle.
- Sign extension: penalties are sign-extended PEN_W to WIDTH.
- Saturating add sat(a,b): sum clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Cell equations:
  - new_E = max(sat(V,open), sat(E,extend))
  - new_F = max(sat(V_in,open), sat(F_in,extend))
  - diag = sat(V_diag, (S==T_in) ? match : mismatch)
  - new_V = max(0, new_E, new_F, diag)
- Active cycle (init_in=1): V, E, F <= new values; col <= col+1, wraps at 2^COL_W.
- Inactive cycle (init_in=0): V <= init_V, E <= init_E, F unchanged, col <= 0.
- Max tracker, updated in the same cycle as V:
  - If init_in and new_V > max_score (strict): max_score <= new_V, max_col <= col (pre-increment value).
  - Ties keep the earliest column.
- Clear: store_S_in=1 on a non-stalled cycle clears max_score/max_col to 0.
  - Clear has priority over a simultaneous update.
- Latency: V_out/E_out/F_out valid 1 cycle after inputs; max_* reflect V_out in the same cycle.
- Config written mid-computation takes effect on the next cell; no flush.

Optional Feature:
- Macro: SW_PE_TRACEBACK_EN.
- Defined: adds output dir_out[1:0], registered with V, same stall/reset (0) rules.
  - Encoding: 0 = zero, 1 = diag, 2 = up (F), 3 = left (E).
  - Priority on ties: zero > diag > up > left.
  - dir_out = 0 when init_in=0.
- Undefined: port absent; no extra logic.

Test Plan:
- Config: cfg_we_in=1, cfg_in={+2,-3,-4,-1}; match S=T=2, V_in→V_diag=5, F_in=0, E=0 → V_out=7, cfg_out/cfg_we_out echo next cycle.
- Saturation: WIDTH=12, V_diag=2046, match=+5, S==T → V_out=2047 (no wrap); mismatch -3 with V_diag=0, gaps negative → V_out=0.
- Gap extend: V=10, E=8, open=-4, extend=-1, mismatch diag → E_out=7 and V_out=max(7,new_F,diag).
- Max tracking: clear via store_S_in, then V sequence 3,9,9,4 at cols 0..3 → max_score_out=9, max_col_out=1; store_S_in pulse → both 0.
- Stall/reset: stall=1 for 3 cycles mid-run → all outputs/col frozen; assert rst asynchronously between clock edges → all outputs 0 immediately.
- Traceback (SW_PE_TRACEBACK_EN): diag=6, F=6, E=2 → dir_out=1; all negative → dir_out=0.
